// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared pause-controller states and register-file constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int REG_ZERO           = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } pause_state_t;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// load_use_detect : combinational load-use hazard comparator
// Rev 1.0
// ============================================================================
`default_nettype none

module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  uses_rt,
  output logic                  hazard
);

  logic w_rt_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  // r0 is hardwired, so a load targeting it can never feed a consumer
  assign w_rt_nonzero = (ex_rt != REG_ADDR_W'(REG_ZERO));
  assign w_rs_match   = (ex_rt == id_rs);
  assign w_rt_match   = uses_rt & (ex_rt == id_rt);
  assign hazard       = memread & w_rt_nonzero & (w_rs_match | w_rt_match);

endmodule

`default_nettype wire

// File: rtl/hazard_pause_ctrl.sv
// ============================================================================
// hazard_pause_ctrl : load-use bubble insertion and memory-busy freeze control
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_pause_ctrl
  import pipeline_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
  parameter int MAX_MEM_WAIT = 15,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_memread,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic                  IF_ID_uses_rt,
  input  logic                  EX_MEM_regwrite,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  ID_EX_flush,
  output logic                  reg_write_pause,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int              WAIT_W     = $clog2(MAX_MEM_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT + 1);
  localparam logic [2:0]      BUB_LOAD   = 3'(STALL_CYCLES - 1);

  pause_state_t      r_state, w_state_next;
  logic [2:0]        r_bub_cnt, w_bub_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
  logic              w_hazard;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .memread (ID_EX_memread),
    .ex_rt   (ID_EX_rt),
    .id_rs   (IF_ID_rs),
    .id_rt   (IF_ID_rt),
    .uses_rt (IF_ID_uses_rt),
    .hazard  (w_hazard)
  );

  always_comb begin
    w_state_next = r_state;
    w_bub_next   = r_bub_cnt;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_busy) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          w_state_next = FREEZE;
        end else if (w_hazard) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
          if (STALL_CYCLES > 1) begin
            w_bub_next   = BUB_LOAD;
            w_state_next = BUBBLE;
          end
        end
      end
      BUBBLE: begin
        // the current bubble still issues; a busy memory parks the remainder
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
        w_bub_next  = r_bub_cnt - 3'd1;
        if (mem_busy)
          w_state_next = FREEZE;
        else if (r_bub_cnt == 3'd1)
          w_state_next = RUN;
      end
      FREEZE: begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        if (!mem_busy)
          w_state_next = (r_bub_cnt != 3'd0) ? BUBBLE : RUN;
      end
      default: begin
        w_state_next = RUN;
        w_bub_next   = 3'd0;
      end
    endcase
  end

  assign w_wait_next = !mem_busy ? '0 :
                       (r_wait_cnt == WAIT_LIMIT) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);

  // a frozen or freezing instruction must not commit its result twice
  assign reg_write_pause = EX_MEM_regwrite & (r_state != FREEZE) &
                           ~((r_state == RUN) & mem_busy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_bub_cnt   <= 3'd0;
      r_wait_cnt  <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_bub_cnt  <= w_bub_next;
      r_wait_cnt <= w_wait_next;
      if (w_wait_next == WAIT_LIMIT)
        mem_timeout <= 1'b1;
      if (!pc_write && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_pause_ctrl.sv
// ============================================================================
// tb_hazard_pause_ctrl : directed self-checking bench, 1-bubble and 3-bubble DUTs
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_pause_ctrl;

  logic       clk;
  logic       rst_n;
  logic       memread;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       uses_rt;
  logic       ex_regwrite;
  logic       mem_busy;

  logic        a_pc, a_ifid, a_flush, a_rwp, a_to;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifid, b_flush, b_rwp, b_to;
  logic [15:0] b_cnt;

  int passed = 0;
  int total  = 0;

  hazard_pause_ctrl #(.STALL_CYCLES(1), .REG_ADDR_W(5), .MAX_MEM_WAIT(15), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ID_EX_memread(memread), .ID_EX_rt(ex_rt),
    .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .IF_ID_uses_rt(uses_rt),
    .EX_MEM_regwrite(ex_regwrite), .mem_busy(mem_busy),
    .pc_write(a_pc), .IF_ID_write(a_ifid), .ID_EX_flush(a_flush),
    .reg_write_pause(a_rwp), .mem_timeout(a_to), .stall_count(a_cnt)
  );

  hazard_pause_ctrl #(.STALL_CYCLES(3), .REG_ADDR_W(5), .MAX_MEM_WAIT(15), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .ID_EX_memread(memread), .ID_EX_rt(ex_rt),
    .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .IF_ID_uses_rt(uses_rt),
    .EX_MEM_regwrite(ex_regwrite), .mem_busy(mem_busy),
    .pc_write(b_pc), .IF_ID_write(b_ifid), .ID_EX_flush(b_flush),
    .reg_write_pause(b_rwp), .mem_timeout(b_to), .stall_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    uses_rt = 1'b0; mem_busy = 1'b0; ex_regwrite = 1'b1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (a_pc !== 1'b1) $display("FAIL reset_pc got=%0b exp=1", a_pc); else passed++;
    total++; if (a_ifid !== 1'b1) $display("FAIL reset_ifid got=%0b exp=1", a_ifid); else passed++;
    total++; if (a_flush !== 1'b0) $display("FAIL reset_flush got=%0b exp=0", a_flush); else passed++;
    total++; if (a_rwp !== 1'b1) $display("FAIL reset_rwp got=%0b exp=1", a_rwp); else passed++;
    total++; if (a_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", a_cnt); else passed++;
    total++; if (a_to !== 1'b0) $display("FAIL reset_timeout got=%0b exp=0", a_to); else passed++;
  endtask

  task automatic test_single_hazard();
    apply_reset();
    memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    total++; if (a_pc !== 1'b0) $display("FAIL single_pc got=%0b exp=0", a_pc); else passed++;
    total++; if (a_flush !== 1'b1) $display("FAIL single_flush got=%0b exp=1", a_flush); else passed++;
    total++; if (a_rwp !== 1'b1) $display("FAIL single_rwp got=%0b exp=1", a_rwp); else passed++;
    next_cycle();
    memread = 1'b0;
    @(negedge clk);
    total++; if (a_pc !== 1'b1) $display("FAIL single_release_pc got=%0b exp=1", a_pc); else passed++;
    total++; if (a_cnt !== 16'd1) $display("FAIL single_cnt got=%0d exp=1", a_cnt); else passed++;
    next_cycle();
    memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    total++; if (a_pc !== 1'b1) $display("FAIL r0_pc got=%0b exp=1", a_pc); else passed++;
    total++; if (a_flush !== 1'b0) $display("FAIL r0_flush got=%0b exp=0", a_flush); else passed++;
    next_cycle();
    memread = 1'b0;
    @(negedge clk);
    total++; if (a_cnt !== 16'd1) $display("FAIL r0_cnt got=%0d exp=1", a_cnt); else passed++;
  endtask

  task automatic test_rt_only();
    apply_reset();
    memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; uses_rt = 1'b0;
    @(negedge clk);
    total++; if (a_pc !== 1'b1) $display("FAIL rt_unused_pc got=%0b exp=1", a_pc); else passed++;
    next_cycle();
    uses_rt = 1'b1;
    @(negedge clk);
    total++; if (a_pc !== 1'b0) $display("FAIL rt_used_pc got=%0b exp=0", a_pc); else passed++;
    total++; if (a_flush !== 1'b1) $display("FAIL rt_used_flush got=%0b exp=1", a_flush); else passed++;
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_multi_bubble();
    apply_reset();
    memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    total++; if (b_flush !== 1'b1) $display("FAIL mb_c1_flush got=%0b exp=1", b_flush); else passed++;
    next_cycle();
    memread = 1'b0; mem_busy = 1'b1;
    @(negedge clk);
    total++; if (b_flush !== 1'b1) $display("FAIL mb_c2_flush got=%0b exp=1", b_flush); else passed++;
    total++; if (b_rwp !== 1'b1) $display("FAIL mb_c2_rwp got=%0b exp=1", b_rwp); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (b_flush !== 1'b0) $display("FAIL mb_f1_flush got=%0b exp=0", b_flush); else passed++;
    total++; if (b_rwp !== 1'b0) $display("FAIL mb_f1_rwp got=%0b exp=0", b_rwp); else passed++;
    total++; if (b_pc !== 1'b0) $display("FAIL mb_f1_pc got=%0b exp=0", b_pc); else passed++;
    next_cycle();
    mem_busy = 1'b0;
    @(negedge clk);
    total++; if (b_flush !== 1'b0) $display("FAIL mb_f2_flush got=%0b exp=0", b_flush); else passed++;
    total++; if (b_rwp !== 1'b0) $display("FAIL mb_f2_rwp got=%0b exp=0", b_rwp); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (b_flush !== 1'b1) $display("FAIL mb_c3_flush got=%0b exp=1", b_flush); else passed++;
    total++; if (b_pc !== 1'b0) $display("FAIL mb_c3_pc got=%0b exp=0", b_pc); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (b_pc !== 1'b1) $display("FAIL mb_done_pc got=%0b exp=1", b_pc); else passed++;
    total++; if (b_flush !== 1'b0) $display("FAIL mb_done_flush got=%0b exp=0", b_flush); else passed++;
    total++; if (b_cnt !== 16'd5) $display("FAIL mb_cnt got=%0d exp=5", b_cnt); else passed++;
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_busy = 1'b1;
    @(negedge clk);
    total++; if (a_rwp !== 1'b0) $display("FAIL to_entry_rwp got=%0b exp=0", a_rwp); else passed++;
    total++; if (a_pc !== 1'b0) $display("FAIL to_entry_pc got=%0b exp=0", a_pc); else passed++;
    for (int j = 1; j <= 19; j++) begin
      next_cycle();
      @(negedge clk);
      if (j == 15) begin
        total++; if (a_to !== 1'b0) $display("FAIL to_early got=%0b exp=0 at freeze %0d", a_to, j); else passed++;
      end
      if (j == 16) begin
        total++; if (a_to !== 1'b1) $display("FAIL to_rise got=%0b exp=1 at freeze %0d", a_to, j); else passed++;
      end
    end
    next_cycle();
    mem_busy = 1'b0;
    next_cycle();
    @(negedge clk);
    total++; if (a_pc !== 1'b1) $display("FAIL to_resume_pc got=%0b exp=1", a_pc); else passed++;
    total++; if (a_to !== 1'b1) $display("FAIL to_sticky got=%0b exp=1", a_to); else passed++;
    total++; if (a_cnt !== 16'd21) $display("FAIL to_cnt got=%0d exp=21", a_cnt); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (a_to !== 1'b1) $display("FAIL to_sticky2 got=%0b exp=1", a_to); else passed++;
    apply_reset();
    @(negedge clk);
    total++; if (a_to !== 1'b0) $display("FAIL to_cleared got=%0b exp=0", a_to); else passed++;
  endtask

  task automatic test_reset_mid_bubble();
    apply_reset();
    memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    next_cycle();
    memread = 1'b0;
    @(negedge clk);
    total++; if (b_flush !== 1'b1) $display("FAIL rmb_bubble_flush got=%0b exp=1", b_flush); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (b_flush !== 1'b0) $display("FAIL rmb_async_flush got=%0b exp=0", b_flush); else passed++;
    total++; if (b_pc !== 1'b1) $display("FAIL rmb_async_pc got=%0b exp=1", b_pc); else passed++;
    total++; if (b_cnt !== 16'd0) $display("FAIL rmb_async_cnt got=%0d exp=0", b_cnt); else passed++;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (b_flush !== 1'b0) $display("FAIL rmb_post_flush got=%0b exp=0", b_flush); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (b_pc !== 1'b1) $display("FAIL rmb_post_pc got=%0b exp=1", b_pc); else passed++;
    total++; if (b_cnt !== 16'd0) $display("FAIL rmb_post_cnt got=%0d exp=0", b_cnt); else passed++;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_hazard();
    test_rt_only();
    test_multi_bubble();
    test_timeout();
    test_reset_mid_bubble();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
